// File: rtl/obi_pkg.sv
// OBI bus request/response types shared by all bus masters.
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/strela_pkg.sv
// Shared STRELA types: input memory node FSM states and the fixed word stride.
package strela_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MREQ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } imn_state_e;

    localparam logic [15:0] WORD_STRIDE = 16'd4;

endpackage

// File: rtl/fifo_v3.sv
// Generic synchronous FIFO with flush and occupancy count; DEPTH must be a power of two.
// Latency: push to head in one cycle (zero with FALL_THROUGH); push dropped when full, pop ignored when empty.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);
    localparam logic [ADDR_DEPTH-1:0] PTR_ONE = ADDR_DEPTH'(1);
    localparam logic [ADDR_DEPTH:0]   CNT_ONE = (ADDR_DEPTH + 1)'(1);

    logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_DEPTH:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  push_ok, pop_ok, bypass;
    logic                  unused_testmode;

    assign unused_testmode = testmode_i;

    // In fall-through mode an empty FIFO presents the incoming word directly.
    assign bypass  = FALL_THROUGH && (cnt_q == '0) && push_i;
    assign full_o  = (cnt_q == (ADDR_DEPTH + 1)'(DEPTH));
    assign empty_o = (cnt_q == '0) && !bypass;
    assign usage_o = cnt_q[ADDR_DEPTH-1:0];
    assign data_o  = bypass ? data_i : mem_q[rd_ptr_q];
    assign pop_ok  = pop_i && (cnt_q != '0);
    assign push_ok = push_i && !full_o && !(bypass && pop_i);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (!push_ok && pop_ok) begin
            cnt_d = cnt_q - CNT_ONE;
        end
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/input_memory_node.sv
// Streams imn_size_i bytes from imn_addr_i over OBI into a FIFO feeding the CGRA; STRELA_IMN_STRIDE_EN adds a byte stride.
// Latency: first request 1 cycle after exec_i, data 1 cycle after rvalid; requests stall when in-flight + buffered reaches FIFO_DEPTH.
module input_memory_node
    import strela_pkg::*;
    import obi_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    output obi_req_t    masters_req_o,
    input  obi_resp_t   masters_resp_i,
    input  logic [31:0] imn_addr_i,
    input  logic [15:0] imn_size_i,
`ifdef STRELA_IMN_STRIDE_EN
    input  logic [15:0] imn_stride_i,
`endif
    input  logic        exec_i,
    output logic        done_o,
    output logic [31:0] dout_o,
    output logic        dout_v_o,
    input  logic        dout_r_i
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned SUM_W = CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    imn_state_e       state_q, state_d;
    logic [15:0]      addr_offset_q, addr_offset_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] fifo_cnt;
    logic [PTR_W-1:0] fifo_usage;
    logic [SUM_W-1:0] inflight;
    logic [15:0]      stride;
    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic             credit, req, gnt_fire, rv_live, rv_drop, last_grant;

`ifdef STRELA_IMN_STRIDE_EN
    logic [15:0] words_q, words_d;
    logic [16:0] words_total;

    // With an arbitrary stride the offset no longer tracks bytes read, so count words instead.
    assign stride      = imn_stride_i;
    assign words_total = ({1'b0, imn_size_i} + 17'd3) >> 2;
    assign last_grant  = ({1'b0, words_q} + 17'd1) >= words_total;
`else
    assign stride      = WORD_STRIDE;
    assign last_grant  = ({1'b0, addr_offset_q} + {1'b0, WORD_STRIDE}) >= {1'b0, imn_size_i};
`endif

    // The FIFO reports usage modulo its depth, so a full FIFO must be counted explicitly.
    assign fifo_cnt = fifo_full ? CNT_W'(FIFO_DEPTH) : CNT_W'(fifo_usage);
    // Reads abandoned by a clear still return data, so they keep holding a slot.
    assign inflight = SUM_W'(outstanding_q) + SUM_W'(drop_q) + SUM_W'(fifo_cnt);
    assign credit   = inflight < SUM_W'(FIFO_DEPTH);

    assign req       = (state_q == S_MREQ) && credit && !clr_i;
    assign gnt_fire  = req && masters_resp_i.gnt;
    assign rv_drop   = masters_resp_i.rvalid && (drop_q != '0);
    assign rv_live   = masters_resp_i.rvalid && (drop_q == '0) && (outstanding_q != '0);
    assign fifo_push = rv_live && !clr_i;
    assign fifo_pop  = dout_v_o && dout_r_i;

    assign done_o   = (state_q == S_DONE);
    assign dout_v_o = !fifo_empty;

    always_comb begin
        masters_req_o       = '0;
        masters_req_o.req   = req;
        masters_req_o.we    = 1'b0;
        masters_req_o.be    = 4'b1111;
        masters_req_o.wdata = '0;
        masters_req_o.addr  = imn_addr_i + {16'h0, addr_offset_q};
    end

    always_comb begin
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        if (gnt_fire && !rv_live) begin
            outstanding_d = outstanding_q + CNT_ONE;
        end else if (!gnt_fire && rv_live) begin
            outstanding_d = outstanding_q - CNT_ONE;
        end
        if (rv_drop) begin
            drop_d = drop_q - CNT_ONE;
        end
        if (clr_i) begin
            drop_d        = drop_d + outstanding_q - (rv_live ? CNT_ONE : '0);
            outstanding_d = '0;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_offset_d = addr_offset_q;
`ifdef STRELA_IMN_STRIDE_EN
        words_d       = words_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (exec_i) begin
                    addr_offset_d = '0;
`ifdef STRELA_IMN_STRIDE_EN
                    words_d       = '0;
`endif
                    state_d       = (imn_size_i == '0) ? S_DONE : S_MREQ;
                end
            end
            S_MREQ: begin
                if (gnt_fire) begin
                    addr_offset_d = addr_offset_q + stride;
`ifdef STRELA_IMN_STRIDE_EN
                    words_d       = words_q + 16'd1;
`endif
                    if (last_grant) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if ((outstanding_q == '0) && fifo_empty) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        if (clr_i) begin
            state_d       = S_IDLE;
            addr_offset_d = '0;
`ifdef STRELA_IMN_STRIDE_EN
            words_d       = '0;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            addr_offset_q <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            addr_offset_q <= addr_offset_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

`ifdef STRELA_IMN_STRIDE_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            words_q <= '0;
        end else begin
            words_q <= words_d;
        end
    end
`endif

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (32),
        .DEPTH        (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (clr_i),
        .testmode_i (1'b0),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .usage_o    (fifo_usage),
        .data_i     (masters_resp_i.rdata),
        .push_i     (fifo_push),
        .data_o     (dout_o),
        .pop_i      (fifo_pop)
    );

endmodule

// File: tb/tb_input_memory_node.sv
// Directed bench for input_memory_node: OBI slave model with tunable gnt/rvalid/ready rates.
module tb_input_memory_node;
    import obi_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr   = 1'b0;
    logic        exec  = 1'b0;
    logic [31:0] base  = 32'h1234_0000;
    logic [15:0] size  = 16'd0;
    obi_req_t    mreq;
    obi_resp_t   mresp = '0;
    logic        done, dout_v;
    logic        dout_r = 1'b0;
    logic [31:0] dout;

    int unsigned gnt_pct = 0, rv_pct = 0, rdy_pct = 0;
    logic [31:0] bus_q[$];
    logic [31:0] gaddr_q[$];
    logic [31:0] got_q[$];
    int          n_grants = 0, rv_n = 0, max_occ = 0;
    bit          req_seen = 1'b0;
    int          checks = 0, passes = 0;

    typedef struct {
        logic [31:0] base;
        logic [15:0] size;
        int unsigned gp;
        int unsigned rp;
        int unsigned dp;
        int          exp_n;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    input_memory_node #(.FIFO_DEPTH(8)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clr_i          (clr),
        .masters_req_o  (mreq),
        .masters_resp_i (mresp),
        .imn_addr_i     (base),
        .imn_size_i     (size),
        .exec_i         (exec),
        .done_o         (done),
        .dout_o         (dout),
        .dout_v_o       (dout_v),
        .dout_r_i       (dout_r)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
    endfunction

    // Slave model: inputs change at the falling edge, handshakes are logged 1 ns later.
    always @(negedge clk) begin
        mresp.gnt = ($urandom_range(99) < gnt_pct);
        if (bus_q.size() > 0 && $urandom_range(99) < rv_pct) begin
            mresp.rvalid = 1'b1;
            mresp.rdata  = mem_word(bus_q.pop_front());
            rv_n++;
        end else begin
            mresp.rvalid = 1'b0;
            mresp.rdata  = '0;
        end
        dout_r = ($urandom_range(99) < rdy_pct);
        #1;
        if (mreq.req) req_seen = 1'b1;
        if (mreq.req && mresp.gnt) begin
            bus_q.push_back(mreq.addr);
            gaddr_q.push_back(mreq.addr);
            n_grants++;
        end
        if (dout_v && dout_r) got_q.push_back(dout);
        if (bus_q.size() + rv_n - got_q.size() > max_occ)
            max_occ = bus_q.size() + rv_n - got_q.size();
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #3;
    endtask

    task automatic clear_bench();
        gaddr_q.delete();
        got_q.delete();
        n_grants = 0;
        rv_n     = 0;
        max_occ  = 0;
        req_seen = 1'b0;
    endtask

    task automatic pulse_clr();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic start(input logic [31:0] b, input logic [15:0] s);
        base = b;
        size = s;
        exec = 1'b1;
        tick();
        exec = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_done_in_time"}, {31'd0, ok}, 32'd1);
    endtask

    task automatic check_stream(input string tag, input logic [31:0] b, input int n);
        int aerr = 0;
        int derr = 0;
        for (int i = 0; i < n; i++) begin
            if (i >= gaddr_q.size() || gaddr_q[i] !== b + 32'(4 * i)) aerr++;
            if (i >= got_q.size() || got_q[i] !== mem_word(b + 32'(4 * i))) derr++;
        end
        chk({tag, "_grants"}, 32'(n_grants), 32'(n));
        chk({tag, "_words"}, 32'(got_q.size()), 32'(n));
        chk({tag, "_addr_errs"}, 32'(aerr), 32'd0);
        chk({tag, "_data_errs"}, 32'(derr), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h0000_1000, 16'd16, 100, 100, 100, 4};
        vecs[1] = '{32'h0000_2000, 16'd6,  100, 100, 100, 2};
        vecs[2] = '{32'h0000_3000, 16'd20,  50,  40,  60, 5};
        vecs[3] = '{32'h0000_4000, 16'd40,  70,  30,  80, 10};
        vecs[4] = '{32'h0000_5FFC, 16'd1,  100, 100, 100, 1};
        vecs[5] = '{32'h0000_8000, 16'd64, 100, 100,  30, 16};

        // Outputs while held in reset.
        #12;
        chk("rst_req", {31'd0, mreq.req}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dout_v", {31'd0, dout_v}, 32'd0);
        chk("rst_addr", mreq.addr, 32'h1234_0000);
        chk("rst_be", {28'd0, mreq.be}, 32'hF);
        chk("rst_we", {31'd0, mreq.we}, 32'd0);
        tick();
        rst_n = 1'b1;

        // Zero-length transfer finishes one cycle after exec without requesting.
        tick();
        chk("size0_idle_done", {31'd0, done}, 32'd0);
        clear_bench();
        start(32'h0000_0100, 16'd0);
        chk("size0_done", {31'd0, done}, 32'd1);
        repeat (3) tick();
        chk("size0_req_seen", {31'd0, req_seen}, 32'd0);
        chk("size0_grants", 32'(n_grants), 32'd0);
        pulse_clr();
        chk("size0_clr_done", {31'd0, done}, 32'd0);

        // Request and data latency.
        clear_bench();
        gnt_pct = 100; rv_pct = 0; rdy_pct = 100;
        tick();
        start(32'h0000_7000, 16'd4);
        chk("lat_req", {31'd0, mreq.req}, 32'd1);
        chk("lat_addr", mreq.addr, 32'h0000_7000);
        rv_pct = 100;
        tick();
        chk("lat_no_data_yet", {31'd0, dout_v}, 32'd0);
        chk("lat_req_drain", {31'd0, mreq.req}, 32'd0);
        tick();
        chk("lat_dout_v", {31'd0, dout_v}, 32'd1);
        chk("lat_dout", dout, mem_word(32'h0000_7000));
        wait_done("lat", 100);
        check_stream("lat", 32'h0000_7000, 1);
        pulse_clr();

        // Table of transfers with assorted bus and consumer rates.
        for (int k = 0; k < 6; k++) begin
            string tag;
            tag = $sformatf("vec%0d", k);
            clear_bench();
            gnt_pct = vecs[k].gp; rv_pct = vecs[k].rp; rdy_pct = vecs[k].dp;
            tick();
            start(vecs[k].base, vecs[k].size);
            wait_done(tag, 3000);
            check_stream(tag, vecs[k].base, vecs[k].exp_n);
            chk({tag, "_occupancy_le_depth"}, {31'd0, (max_occ <= 8)}, 32'd1);
            pulse_clr();
            chk({tag, "_clr_done"}, {31'd0, done}, 32'd0);
        end

        // Consumer stalled: credit stops requests at FIFO_DEPTH, then all words drain.
        clear_bench();
        gnt_pct = 100; rv_pct = 100; rdy_pct = 0;
        tick();
        start(32'h0000_9000, 16'd64);
        repeat (30) tick();
        chk("bp_grants_stalled", 32'(n_grants), 32'd8);
        chk("bp_req_low", {31'd0, mreq.req}, 32'd0);
        chk("bp_nothing_consumed", 32'(got_q.size()), 32'd0);
        chk("bp_dout_v", {31'd0, dout_v}, 32'd1);
        rdy_pct = 100;
        wait_done("bp", 500);
        check_stream("bp", 32'h0000_9000, 16);
        pulse_clr();

        // Clear with two reads in flight; their late data must not reach the CGRA.
        clear_bench();
        gnt_pct = 100; rv_pct = 0; rdy_pct = 100;
        tick();
        start(32'h0000_A000, 16'd32);
        tick();
        gnt_pct = 0;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("abort_grants", 32'(n_grants), 32'd2);
        chk("abort_req", {31'd0, mreq.req}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_dout_v", {31'd0, dout_v}, 32'd0);
        clear_bench();
        gnt_pct = 100; rv_pct = 100;
        start(32'h0000_B000, 16'd12);
        wait_done("restart", 500);
        check_stream("restart", 32'h0000_B000, 3);
        chk("restart_bus_idle", 32'(bus_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
